memory_bus_arbiter: RTL

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_pkg.sv | 12 +
 rtl/memory_bus_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared helpers for the memory bus arbiter.
// Only sizing arithmetic lives here; all encodings stay local to the arbiter.
package memory_bus_arbiter_pkg;

  function automatic int counter_width(input int max_count);
    int w;
    w = 1;
    while ((1 << w) < (max_count + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single memory port,
// with round-robin or data-priority arbitration and an optional response timeout.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_PRIORITY  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_read,
  input  logic [ADDR_WIDTH-1:0] instr_address,
  output logic [DATA_WIDTH-1:0] instr_read_data,
  output logic                  instr_response,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  output logic [DATA_WIDTH-1:0] data_read_data,
  output logic                  data_response,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  localparam logic LAST_INSTR = 1'b0;
  localparam logic LAST_DATA  = 1'b1;
  localparam int   CNT_W      = counter_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] count;
  logic             data_req;
  logic             pick_data;
  logic             timed_out;

  // A tie goes to whichever port did not win last time, unless data has priority.
  always_comb begin
    data_req  = data_read | data_write;
    pick_data = 1'b0;
    if (data_req && !instr_read)
      pick_data = 1'b1;
    else if (data_req && instr_read)
      pick_data = (DATA_PRIORITY != 0) || (last_grant == LAST_INSTR);
    timed_out = (TIMEOUT_CYCLES != 0) && (count == LAST_COUNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= LAST_DATA;
      count           <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_write_data  <= '0;
      instr_read_data <= '0;
      data_read_data  <= '0;
      instr_response  <= 1'b0;
      data_response   <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      instr_response <= 1'b0;
      data_response  <= 1'b0;
      timeout_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req || instr_read) begin
            count <= '0;
            if (pick_data) begin
              state          <= GRANT_D;
              last_grant     <= LAST_DATA;
              mem_address    <= data_address;
              mem_write_data <= data_write_data;
              mem_write      <= data_write;
              mem_read       <= !data_write;
            end else begin
              state          <= GRANT_I;
              last_grant     <= LAST_INSTR;
              mem_address    <= instr_address;
              mem_write_data <= '0;
              mem_write      <= 1'b0;
              mem_read       <= 1'b1;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // A response landing on the final timeout cycle still completes normally.
          if (mem_response || timed_out) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            timeout_error <= !mem_response;
            state         <= DONE;
            if (state == GRANT_I) begin
              instr_response  <= 1'b1;
              instr_read_data <= mem_response ? mem_read_data : '0;
            end else begin
              data_response <= 1'b1;
              if (!mem_response)
                data_read_data <= '0;
              else if (mem_read)
                data_read_data <= mem_read_data;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
